// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues pc to a synchronous instruction memory, captures the
// returned word and hands it to decode over a valid/ready handshake, with redirect support.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data_out,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        ISSUE,
        CAPTURE,
        VALID,
        ERR
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    logic [31:0] pc;
    logic        redirect_ok;
    logic        redirect_bad;

    assign imem_address = pc;
    assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ISSUE;
            pc           <= RESET_PC;
            instr        <= NOP;
            instr_pc     <= RESET_PC;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= 16'h0000;
        end else begin
            case (state)
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    instr       <= imem_data_out;
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    state       <= VALID;
                end
                VALID: begin
                    if (instr_ready) begin
                        fetch_count <= fetch_count + 16'd1;
                        pc          <= pc + 32'd4;
                        instr_valid <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ERR: ;
            endcase

            // NOTE: redirects are written after the case so their non-blocking updates
            // override the normal next-state and next-pc, while a same-edge transfer still counts.
            if (state != ERR) begin
                if (redirect_bad) begin
                    pc           <= pc;
                    instr_valid  <= 1'b0;
                    misalign_err <= 1'b1;
                    state        <= ERR;
                end else if (redirect_ok) begin
                    pc          <= redirect_pc;
                    instr_valid <= 1'b0;
                    state       <= ISSUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table plus hand-written
// sequences for stall, redirect-with-transfer, misalignment and mid-fetch reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_address;
    logic [31:0] imem_data_out;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;
    logic [15:0] fetch_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_addr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(.RESET_PC(32'h0000_1000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_address   (imem_address),
        .imem_data_out  (imem_data_out),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16]};
    endfunction

    // Synchronous instruction memory: data for the sampled address appears the next cycle.
    always @(posedge clk) imem_data_out <= word(imem_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] eipc, input logic [31:0] eaddr,
                       input logic [15:0] ecnt);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_ipc = eipc; v.e_addr = eaddr; v.e_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " valid"},    {31'b0, instr_valid},  32'h0);
        check({tag, " err"},      {31'b0, misalign_err}, 32'h0);
        check({tag, " count"},    {16'b0, fetch_count},  32'h0);
        check({tag, " address"},  imem_address,          32'h0000_1000);
        check({tag, " instr"},    instr,                 32'h0000_0013);
        check({tag, " instr_pc"}, instr_pc,              32'h0000_1000);
    endtask

    initial begin
        reset          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Table: rv, rpc, rdy -> valid, instr_pc, imem_address, fetch_count after the edge.
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_1000, 16'd0); // ISSUE->CAPTURE
        add(0, 32'h0,         1, 1, 32'h0000_1000, 32'h0000_1000, 16'd0);
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_1004, 16'd1);
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_1004, 16'd1);
        add(0, 32'h0,         1, 1, 32'h0000_1004, 32'h0000_1004, 16'd1);
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_1008, 16'd2);
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_1008, 16'd2);
        add(0, 32'h0,         1, 1, 32'h0000_1008, 32'h0000_1008, 16'd2);
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_100C, 16'd3);
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_100C, 16'd3); // now in CAPTURE
        add(1, 32'h0000_2000, 1, 0, 32'h0,         32'h0000_2000, 16'd3); // redirect in CAPTURE
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_2000, 16'd3);
        add(0, 32'h0,         1, 1, 32'h0000_2000, 32'h0000_2000, 16'd3);
        add(1, 32'h0000_3000, 1, 0, 32'h0,         32'h0000_3000, 16'd4); // redirect + transfer
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_3000, 16'd4);
        add(0, 32'h0,         1, 1, 32'h0000_3000, 32'h0000_3000, 16'd4);
        add(1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'hFFFF_FFFC, 16'd4); // drop held instr
        add(0, 32'h0,         0, 0, 32'h0,         32'hFFFF_FFFC, 16'd4);
        add(0, 32'h0,         0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 16'd4);
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_0000, 16'd5); // pc wraps
        add(0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 16'd5);
        add(0, 32'h0,         0, 1, 32'h0000_0000, 32'h0000_0000, 16'd5);
        add(0, 32'h0,         0, 1, 32'h0000_0000, 32'h0000_0000, 16'd5);
        add(0, 32'h0,         1, 0, 32'h0,         32'h0000_0004, 16'd6);

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b1;

        foreach (vecs[i]) begin
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            instr_ready    = vecs[i].rdy;
            step();
            check($sformatf("v%0d valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d address", i), imem_address, vecs[i].e_addr);
            check($sformatf("v%0d count", i), {16'b0, fetch_count}, {16'b0, vecs[i].e_cnt});
            check($sformatf("v%0d err", i), {31'b0, misalign_err}, 32'h0);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].e_ipc);
                check($sformatf("v%0d instr", i), instr, word(vecs[i].e_ipc));
            end
        end

        // Stall for five cycles while VALID, then one transfer.
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step();
        step();
        check("stall first valid", {31'b0, instr_valid}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("stall%0d valid", k), {31'b0, instr_valid}, 32'h1);
            check($sformatf("stall%0d instr_pc", k), instr_pc, 32'h0000_1000);
            check($sformatf("stall%0d instr", k), instr, word(32'h0000_1000));
        end
        instr_ready = 1'b1;
        step();
        check("stall release valid", {31'b0, instr_valid}, 32'h0);
        check("stall release count", {16'b0, fetch_count}, 32'd1);
        check("stall release address", imem_address, 32'h0000_1004);

        // Redirect on the same edge as the transfer at 0x1004.
        step();
        step();
        check("pre-redirect instr_pc", instr_pc, 32'h0000_1004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        step();
        redirect_valid = 1'b0;
        check("redir+xfer count", {16'b0, fetch_count}, 32'd2);
        check("redir+xfer address", imem_address, 32'h0000_3000);
        step();
        step();
        check("redir+xfer valid", {31'b0, instr_valid}, 32'h1);
        check("redir+xfer instr_pc", instr_pc, 32'h0000_3000);
        check("redir+xfer instr", instr, word(32'h0000_3000));

        // Misaligned redirect is terminal until reset.
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        step();
        check("misalign err", {31'b0, misalign_err}, 32'h1);
        check("misalign valid", {31'b0, instr_valid}, 32'h0);
        check("misalign address", imem_address, 32'h0000_3000);
        redirect_pc = 32'h0000_4000;
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("err%0d err", k), {31'b0, misalign_err}, 32'h1);
            check($sformatf("err%0d valid", k), {31'b0, instr_valid}, 32'h0);
            check($sformatf("err%0d address", k), imem_address, 32'h0000_3000);
            check($sformatf("err%0d count", k), {16'b0, fetch_count}, 32'd2);
        end
        redirect_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_values("err reset");
        reset = 1'b1;

        // Reset asserted while in CAPTURE, then a clean restart.
        step();
        check("capture valid", {31'b0, instr_valid}, 32'h0);
        reset = 1'b0;
        #1;
        check_reset_values("mid reset");
        reset = 1'b1;
        step();
        step();
        check("restart valid", {31'b0, instr_valid}, 32'h1);
        check("restart instr_pc", instr_pc, 32'h0000_1000);
        check("restart instr", instr, word(32'h0000_1000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
